// File: rtl/wbm_arbiter_if.sv
// Bundle of the per-master request bank and the shared slave-side bus
// seen by wbm_arbiter. The arbiter uses the slave modport; the environment uses master.
interface wbm_arbiter_if #(
   parameter int NUM_MASTERS    = 2,
   parameter int BUS_DATA_WIDTH = 32,
   parameter int BUS_ADDR_WIDTH = 32
);
   logic [NUM_MASTERS-1:0]                wbm_cyc_i;
   logic [NUM_MASTERS-1:0]                wbm_stb_i;
   logic [NUM_MASTERS-1:0]                wbm_we_i;
   logic [NUM_MASTERS*4-1:0]              wbm_sel_i;
   logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] wbm_adr_i;
   logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] wbm_dat_i;
   logic [BUS_DATA_WIDTH-1:0]             wbm_dat_o;
   logic [NUM_MASTERS-1:0]                wbm_ack_o;
   logic [NUM_MASTERS-1:0]                wbm_err_o;
   logic [NUM_MASTERS-1:0]                wbm_gnt_o;
   logic                                  wbs_cyc_o;
   logic                                  wbs_stb_o;
   logic                                  wbs_we_o;
   logic [3:0]                            wbs_sel_o;
   logic [BUS_ADDR_WIDTH-1:0]             wbs_adr_o;
   logic [BUS_DATA_WIDTH-1:0]             wbs_dat_o;
   logic [BUS_DATA_WIDTH-1:0]             wbs_dat_i;
   logic                                  wbs_ack_i;
   logic                                  wbs_err_i;

   // Handshake: a transfer completes on a cycle where cyc&stb are high and ack
   // or err is high; err wins over ack. cyc high without a break locks the bus.
   modport slave (
      input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_gnt_o,
      output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
   );

   modport master (
      output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
      output wbs_dat_i, wbs_ack_i, wbs_err_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_gnt_o,
      input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
   );
endinterface

// File: rtl/wbm_arbiter.sv
// Round-robin Wishbone arbiter: one owner per bus cycle (cyc), with an ack
// watchdog that ends a hung transfer by pulsing err to the owner.
module wbm_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int BUS_DATA_WIDTH = 32,
   parameter int BUS_ADDR_WIDTH = 32,
   parameter int TIMEOUT        = 10
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   wbm_arbiter_if.slave bus,
   output logic [1:0]  dbg_state_o
);
   localparam int NM = NUM_MASTERS;
   localparam int DW = BUS_DATA_WIDTH;
   localparam int AW = BUS_ADDR_WIDTH;
   localparam int LW = (NM > 1) ? $clog2(NM) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ABORT = 2'd2} state_t;

   state_t          state_q;
   logic [NM-1:0]   gnt_q;
   logic [NM-1:0]   gnt_d;
   logic [NM-1:0]   err_pulse_q;
   logic [LW-1:0]   last_q;
   logic [7:0]      wd_q;

   logic            sel_cyc, sel_stb, sel_we;
   logic [3:0]      sel_sel;
   logic [AW-1:0]   sel_adr;
   logic [DW-1:0]   sel_dat;
   logic            win_found;
   logic [LW-1:0]   win_idx;
   logic            granted;

   always_comb begin
      sel_cyc = 1'b0;
      sel_stb = 1'b0;
      sel_we  = 1'b0;
      sel_sel = '0;
      sel_adr = '0;
      sel_dat = '0;
      for (int i = 0; i < NM; i++) begin
         if (gnt_q[i]) begin
            sel_cyc = bus.wbm_cyc_i[i];
            sel_stb = bus.wbm_stb_i[i];
            sel_we  = bus.wbm_we_i[i];
            sel_sel = bus.wbm_sel_i[4*i +: 4];
            sel_adr = bus.wbm_adr_i[AW*i +: AW];
            sel_dat = bus.wbm_dat_i[DW*i +: DW];
         end
      end
   end

   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NM; k++) begin
         if (!win_found && bus.wbm_cyc_i[LW'((int'(last_q) + k) % NM)]) begin
            win_found = 1'b1;
            win_idx   = LW'((int'(last_q) + k) % NM);
         end
      end
      gnt_d = NM'(1) << win_idx;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         err_pulse_q <= '0;
         last_q      <= LW'(NM - 1);
         wd_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               wd_q        <= '0;
               err_pulse_q <= '0;
               if (win_found) begin
                  gnt_q   <= gnt_d;
                  last_q  <= win_idx;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (!sel_cyc) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  wd_q    <= '0;
               end else if (sel_stb && !bus.wbs_ack_i && !bus.wbs_err_i) begin
                  if (wd_q == 8'(TIMEOUT - 1)) begin
                     state_q     <= ABORT;
                     err_pulse_q <= gnt_q;
                     wd_q        <= '0;
                  end else begin
                     wd_q <= wd_q + 8'd1;
                  end
               end else begin
                  wd_q <= '0;
               end
            end
            ABORT: begin
               err_pulse_q <= '0;
               if (!sel_cyc) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign granted = (state_q == GRANT);

   assign bus.wbs_cyc_o = granted & sel_cyc;
   assign bus.wbs_stb_o = granted & sel_stb;
   assign bus.wbs_we_o  = granted & sel_we;
   assign bus.wbs_sel_o = granted ? sel_sel : 4'h0;
   assign bus.wbs_adr_o = granted ? sel_adr : '0;
   assign bus.wbs_dat_o = granted ? sel_dat : '0;

   // In ABORT the only thing a master sees is the one-cycle timeout err.
   assign bus.wbm_ack_o = granted ? (gnt_q & {NM{bus.wbs_ack_i & ~bus.wbs_err_i}}) : '0;
   assign bus.wbm_err_o = granted ? (gnt_q & {NM{bus.wbs_err_i}}) : err_pulse_q;
   assign bus.wbm_gnt_o = gnt_q;
   assign bus.wbm_dat_o = bus.wbs_dat_i;

   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_wbm_arbiter.sv
// Directed bench for wbm_arbiter with two masters and TIMEOUT=10.
module tb_wbm_arbiter;
  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 10;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;

  wbm_arbiter_if #(.NUM_MASTERS(NM), .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW)) bus ();

  wbm_arbiter #(.NUM_MASTERS(NM), .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_we_i  = '0;
    bus.wbm_sel_i = '0;
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_ack_i = 1'b0;
    bus.wbs_err_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.wbm_cyc_i = 2'b11;
    bus.wbm_stb_i = 2'b11;
    bus.wbm_we_i  = 2'b11;
    bus.wbm_sel_i = 8'hFF;
    bus.wbm_adr_i = {2{32'hFFFF_FFFF}};
    bus.wbm_dat_i = {2{32'h1234_5678}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", bus.wbm_gnt_o); end
    total++; if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o}); end
    total++; if ({bus.wbs_sel_o, bus.wbs_adr_o, bus.wbs_dat_o} !== 68'h0) begin bad++; $display("FAIL reset_bus: sel=%h adr=%h dat=%h want 0", bus.wbs_sel_o, bus.wbs_adr_o, bus.wbs_dat_o); end
    total++; if ({bus.wbm_ack_o, bus.wbm_err_o} !== 4'b0000) begin bad++; $display("FAIL reset_ackerr: ack=%b err=%b want 0", bus.wbm_ack_o, bus.wbm_err_o); end
    total++; if (bus.wbm_dat_o !== 32'h0) begin bad++; $display("FAIL reset_rdat: got %h want 0", bus.wbm_dat_o); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    step();
    total++; if (bus.wbm_gnt_o !== 2'b01) begin bad++; $display("FAIL reset_first_gnt: got %b want 01", bus.wbm_gnt_o); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_single_write();
    apply_reset();
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    bus.wbm_we_i[0]  = 1'b1;
    bus.wbm_sel_i[3:0] = 4'hF;
    bus.wbm_adr_i[31:0] = 32'h0000_0008;
    bus.wbm_dat_i[31:0] = 32'h0101_0101;
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b00) begin bad++; $display("FAIL wr_gnt_early: got %b want 00", bus.wbm_gnt_o); end
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b01) begin bad++; $display("FAIL wr_gnt: got %b want 01", bus.wbm_gnt_o); end
    total++; if (bus.wbs_adr_o !== 32'h8 || bus.wbs_dat_o !== 32'h0101_0101) begin bad++; $display("FAIL wr_bus: adr=%h dat=%h want 8/01010101", bus.wbs_adr_o, bus.wbs_dat_o); end
    total++; if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_sel_o} !== 7'b111_1111) begin bad++; $display("FAIL wr_ctl: got %b want 1111111", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_sel_o}); end
    total++; if (bus.wbm_ack_o !== 2'b00) begin bad++; $display("FAIL wr_ack_early: got %b want 00", bus.wbm_ack_o); end
    step();
    bus.wbs_ack_i = 1'b1;
    @(negedge clk);
    total++; if (bus.wbm_ack_o !== 2'b01) begin bad++; $display("FAIL wr_ack: got %b want 01", bus.wbm_ack_o); end
    step();
    bus.wbs_ack_i = 1'b0;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    @(negedge clk);
    total++; if (bus.wbm_ack_o !== 2'b00 || bus.wbs_cyc_o !== 1'b0) begin bad++; $display("FAIL wr_release: ack=%b cyc=%b want 00/0", bus.wbm_ack_o, bus.wbs_cyc_o); end
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b00) begin bad++; $display("FAIL wr_gnt_idle: got %b want 00", bus.wbm_gnt_o); end
  endtask

  task automatic test_contention();
    apply_reset();
    bus.wbm_cyc_i = 2'b11;
    bus.wbm_stb_i = 2'b11;
    bus.wbm_adr_i = {32'h0000_0200, 32'h0000_0100};
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b01 || bus.wbs_adr_o !== 32'h100) begin bad++; $display("FAIL cont_first: gnt=%b adr=%h want 01/100", bus.wbm_gnt_o, bus.wbs_adr_o); end
    step();
    bus.wbm_cyc_i[0] = 1'b0;
    bus.wbm_stb_i[0] = 1'b0;
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b00 || bus.wbs_cyc_o !== 1'b0) begin bad++; $display("FAIL cont_dead: gnt=%b cyc=%b want 00/0", bus.wbm_gnt_o, bus.wbs_cyc_o); end
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b10 || bus.wbs_adr_o !== 32'h200) begin bad++; $display("FAIL cont_second: gnt=%b adr=%h want 10/200", bus.wbm_gnt_o, bus.wbs_adr_o); end
    step();
    bus.wbm_cyc_i = 2'b00;
    bus.wbm_stb_i = 2'b00;
    step();
    bus.wbm_cyc_i = 2'b11;
    bus.wbm_stb_i = 2'b11;
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b01) begin bad++; $display("FAIL cont_rotate: got %b want 01", bus.wbm_gnt_o); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_locked_cycle();
    apply_reset();
    bus.wbm_cyc_i[1] = 1'b1;
    bus.wbm_stb_i[1] = 1'b1;
    bus.wbm_adr_i[63:32] = 32'h1;
    step();
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b10 || bus.wbm_ack_o !== 2'b10) begin bad++; $display("FAIL lock_rd1: gnt=%b ack=%b want 10/10", bus.wbm_gnt_o, bus.wbm_ack_o); end
    total++; if (bus.wbm_dat_o !== 32'hDEAD_BEEF || bus.wbs_adr_o !== 32'h1) begin bad++; $display("FAIL lock_rd1_data: dat=%h adr=%h want deadbeef/1", bus.wbm_dat_o, bus.wbs_adr_o); end
    step();
    bus.wbm_adr_i[63:32] = 32'h2;
    bus.wbs_dat_i = 32'hAFAF_AFAF;
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b10 || bus.wbm_ack_o !== 2'b10) begin bad++; $display("FAIL lock_rd2: gnt=%b ack=%b want 10/10", bus.wbm_gnt_o, bus.wbm_ack_o); end
    total++; if (bus.wbm_dat_o !== 32'hAFAF_AFAF || bus.wbs_adr_o !== 32'h2) begin bad++; $display("FAIL lock_rd2_data: dat=%h adr=%h want afafafaf/2", bus.wbm_dat_o, bus.wbs_adr_o); end
    step();
    bus.wbs_ack_i = 1'b0;
    bus.wbm_cyc_i[1] = 1'b0;
    bus.wbm_stb_i[1] = 1'b0;
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b10 || bus.wbs_cyc_o !== 1'b0) begin bad++; $display("FAIL lock_drop: gnt=%b cyc=%b want 10/0", bus.wbm_gnt_o, bus.wbs_cyc_o); end
    step();
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b01) begin bad++; $display("FAIL lock_pending: got %b want 01", bus.wbm_gnt_o); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_err_wins();
    apply_reset();
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    step();
    bus.wbs_ack_i = 1'b1;
    bus.wbs_err_i = 1'b1;
    bus.wbm_cyc_i[1] = 1'b1;
    bus.wbm_stb_i[1] = 1'b1;
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 2'b01 || bus.wbm_ack_o !== 2'b00) begin bad++; $display("FAIL errwin: err=%b ack=%b want 01/00", bus.wbm_err_o, bus.wbm_ack_o); end
    step();
    bus.wbs_ack_i = 1'b0;
    bus.wbs_err_i = 1'b0;
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b01) begin bad++; $display("FAIL errwin_hold: got %b want 01", bus.wbm_gnt_o); end
    bus.wbm_cyc_i[0] = 1'b0;
    bus.wbm_stb_i[0] = 1'b0;
    step();
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b10) begin bad++; $display("FAIL errwin_next: got %b want 10", bus.wbm_gnt_o); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    bus.wbm_adr_i[31:0] = 32'hDEAD_0000;
    step();
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      total++; if (bus.wbm_err_o !== 2'b00 || bus.wbs_cyc_o !== 1'b1) begin bad++; $display("FAIL to_wait%0d: err=%b cyc=%b want 00/1", k, bus.wbm_err_o, bus.wbs_cyc_o); end
      step();
    end
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 2'b01 || bus.wbs_cyc_o !== 1'b0) begin bad++; $display("FAIL to_pulse: err=%b cyc=%b want 01/0", bus.wbm_err_o, bus.wbs_cyc_o); end
    step();
    bus.wbs_ack_i = 1'b1;
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 2'b00 || bus.wbm_ack_o !== 2'b00 || bus.wbs_cyc_o !== 1'b0) begin bad++; $display("FAIL to_abort: err=%b ack=%b cyc=%b want 00/00/0", bus.wbm_err_o, bus.wbm_ack_o, bus.wbs_cyc_o); end
    total++; if (bus.wbm_gnt_o !== 2'b01) begin bad++; $display("FAIL to_abort_gnt: got %b want 01", bus.wbm_gnt_o); end
    step();
    bus.wbs_ack_i = 1'b0;
    bus.wbm_cyc_i[0] = 1'b0;
    bus.wbm_stb_i[0] = 1'b0;
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b00 || dbg_state !== 2'd0) begin bad++; $display("FAIL to_idle: gnt=%b state=%0d want 00/0", bus.wbm_gnt_o, dbg_state); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.wbm_cyc_i[1] = 1'b1;
    bus.wbm_stb_i[1] = 1'b1;
    bus.wbm_we_i[1]  = 1'b1;
    bus.wbm_adr_i[63:32] = 32'h40;
    bus.wbm_dat_i[63:32] = 32'h55;
    step();
    #1;
    total++; if (bus.wbs_cyc_o !== 1'b1 || bus.wbm_gnt_o !== 2'b10) begin bad++; $display("FAIL ar_busy: cyc=%b gnt=%b want 1/10", bus.wbs_cyc_o, bus.wbm_gnt_o); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.wbs_cyc_o !== 1'b0 || bus.wbm_gnt_o !== 2'b00 || bus.wbs_stb_o !== 1'b0) begin bad++; $display("FAIL ar_instant: cyc=%b stb=%b gnt=%b want 0/0/00", bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbm_gnt_o); end
    bus.wbm_cyc_i = 2'b11;
    bus.wbm_stb_i = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    total++; if (bus.wbm_gnt_o !== 2'b01) begin bad++; $display("FAIL ar_restart: got %b want 01", bus.wbm_gnt_o); end
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single_write();
    test_contention();
    test_locked_cycle();
    test_err_wins();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
